// File: rtl/pool_pkg.sv
// pool_pkg: types and constants shared by the pool window feeder, the
// max-pool unit and their benches.
//   DW        - pixel width in bits
//   GRP       - columns per window
//   WIN_BYTES - pixels per 2-row window
//   state_t   - feeder FSM state encoding
package pool_pkg;
  localparam int DW        = 8;
  localparam int GRP       = 6;
  localparam int WIN_BYTES = 2 * GRP;

  typedef enum logic [1:0] {
    FILL_TOP = 2'd0,
    FILL_BOT = 2'd1,
    EMIT     = 2'd2
  } state_t;
endpackage

// File: rtl/pool_window_feeder_if.sv
// pool_window_feeder_if: pixel-stream input and window-output bus of the
// feeder.
//   pix_in/pix_valid/pix_ready - raster-order pixel stream (valid/ready)
//   win_data/win_valid         - 2x6 window; byte i = win_data[i*DW +: DW]
//   win_ready                  - pool stage has consumed the window
//   frame_done                 - one-cycle pulse after the last window of a frame
// master = feeder side, slave = the environment (upstream + pool stage).
interface pool_window_feeder_if;
  import pool_pkg::*;

  logic [DW-1:0]           pix_in;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [WIN_BYTES*DW-1:0] win_data;
  logic                    win_valid;
  logic                    win_ready;
  logic                    frame_done;

  modport master (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_data, win_valid, frame_done
  );

  modport slave (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_data, win_valid, frame_done
  );
endinterface

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one feature-map row of pixels.
//   clk   - write clock
//   we    - write enable; waddr/wdata - write port
//   raddr - base column of a GRP-wide read
//   rdata - entries raddr .. raddr+GRP-1, combinational
// The array is not reset: every entry is written during the top-row fill
// before it is ever read.
module pool_line_buffer import pool_pkg::*; #(
  parameter int W = 24,
  localparam int AW = $clog2(W)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [AW-1:0]          raddr,
  output logic [GRP-1:0][DW-1:0] rdata
);
  logic [DW-1:0] mem [W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  for (genvar i = 0; i < GRP; i++) begin : g_rd
    assign rdata[i] = mem[raddr + AW'(i)];
  end
endmodule

// File: rtl/pool_window_feeder.sv
// pool_window_feeder: turns a raster-order pixel stream into 2-row x GRP-column
// windows for the max-pool stage.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - pool_window_feeder_if.master (pixel in, window out, frame_done)
// Even rows go to the line buffer; odd-row pixels are gathered GRP at a time
// and paired with the matching line-buffer slice. Each window is held until
// the pool stage accepts it, with the pixel input stalled meanwhile.
module pool_window_feeder import pool_pkg::*; #(
  parameter int W = 24,
  parameter int H = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  pool_window_feeder_if.master bus
);
  localparam int CW = $clog2(W + 1);
  localparam int RW = $clog2(H / 2 + 1);
  localparam int AW = $clog2(W);

  state_t                        state;
  logic [CW-1:0]                 col;
  logic [RW-1:0]                 rowpair;
  logic [2:0]                    grp_cnt;
  logic [DW-1:0]                 bot_sr [GRP-1];
  logic [GRP-1:0][DW-1:0]        top;
  logic [WIN_BYTES-1:0][DW-1:0]  win_next;
  logic                          pix_ready_q, win_valid_q, frame_done_q;
  logic [WIN_BYTES*DW-1:0]       win_data_q;
  logic                          pix_xfer, win_xfer, lb_we;
  logic [AW-1:0]                 lb_raddr;

  assign pix_xfer = bus.pix_valid && pix_ready_q;
  assign win_xfer = win_valid_q && bus.win_ready;
  assign lb_we    = (state == FILL_TOP) && pix_xfer;
  // col - grp_cnt is the first column of the group being assembled
  assign lb_raddr = AW'(col - CW'(grp_cnt));

  pool_line_buffer #(.W(W)) u_lb (
    .clk   (clk),
    .we    (lb_we),
    .waddr (AW'(col)),
    .wdata (bus.pix_in),
    .raddr (lb_raddr),
    .rdata (top)
  );

  // Window as it will be latched on the 6th bottom-row pixel: the pixel on
  // the bus this cycle is the last bottom byte.
  always_comb begin
    win_next = '0;
    for (int i = 0; i < GRP; i++) win_next[i] = top[i];
    for (int i = 0; i < GRP - 1; i++) win_next[GRP+i] = bot_sr[i];
    win_next[WIN_BYTES-1] = bus.pix_in;
  end

  // Bottom-row staging: data only, no reset needed.
  always_ff @(posedge clk)
    if (state == FILL_BOT && pix_xfer && grp_cnt != 3'(GRP - 1))
      bot_sr[grp_cnt] <= bus.pix_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL_TOP;
      col          <= '0;
      rowpair      <= '0;
      grp_cnt      <= '0;
      pix_ready_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        FILL_TOP: begin
          pix_ready_q <= 1'b1;
          if (pix_xfer) begin
            if (col == CW'(W - 1)) begin
              col   <= '0;
              state <= FILL_BOT;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FILL_BOT: begin
          pix_ready_q <= 1'b1;
          if (pix_xfer) begin
            col     <= col + 1'b1;
            grp_cnt <= grp_cnt + 1'b1;
            if (grp_cnt == 3'(GRP - 1)) begin
              win_data_q  <= win_next;
              win_valid_q <= 1'b1;
              pix_ready_q <= 1'b0;
              state       <= EMIT;
            end
          end
        end
        EMIT: begin
          if (win_xfer) begin
            win_valid_q <= 1'b0;
            grp_cnt     <= '0;
            pix_ready_q <= 1'b1;
            if (col != CW'(W)) begin
              state <= FILL_BOT;
            end else begin
              col   <= '0;
              state <= FILL_TOP;
              if (rowpair == RW'(H / 2 - 1)) begin
                rowpair      <= '0;
                frame_done_q <= 1'b1;
              end else begin
                rowpair <= rowpair + 1'b1;
              end
            end
          end
        end
        default: state <= FILL_TOP;
      endcase
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_data   = win_data_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder. Two instances share clk/rst: dut_s (H=2) for
// short frames and dut_f (H=24) for a full frame; sel picks which one sees the
// stimulus and is observed. Expected windows are cut straight from the frame
// image (2x6 slices in rowpair/group order).
module tb_pool_window_feeder;
  localparam int W = 24;
  localparam logic [95:0] W3 = {12{8'h03}};
  localparam logic [95:0] W7 = {12{8'h07}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix = '0;
  logic       pv = 1'b0, wr = 1'b0, sel = 1'b0;

  pool_window_feeder_if bs ();
  pool_window_feeder_if bf ();

  assign bs.pix_in = pix;  assign bs.pix_valid = pv & ~sel;  assign bs.win_ready = wr & ~sel;
  assign bf.pix_in = pix;  assign bf.pix_valid = pv & sel;   assign bf.win_ready = wr & sel;

  pool_window_feeder #(.W(W), .H(2))  dut_s (.clk(clk), .rst(rst), .bus(bs));
  pool_window_feeder #(.W(W), .H(24)) dut_f (.clk(clk), .rst(rst), .bus(bf));

  wire        o_pr = sel ? bf.pix_ready  : bs.pix_ready;
  wire        o_wv = sel ? bf.win_valid  : bs.win_valid;
  wire [95:0] o_wd = sel ? bf.win_data   : bs.win_data;
  wire        o_fd = sel ? bf.frame_done : bs.frame_done;

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [95:0] got [$];
  logic [7:0]  img [$];
  int fd_cnt = 0, acc_cnt = 0, wv_cycles = 0, cyc = 0, a0 = 0, last_win_cyc = 0, fd_cyc = 0;

  // Observe handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (o_pr && pv) begin if (acc_cnt == 0) a0 = cyc; acc_cnt++; end
      if (o_wv) wv_cycles++;
      if (o_wv && wr) begin got.push_back(o_wd); last_win_cyc = cyc; end
      if (o_fd) begin fd_cnt++; fd_cyc = cyc; end
    end
  end

  function automatic logic [95:0] exp_win(input int k);
    int rp = k / (W / 6);
    int g  = k % (W / 6);
    logic [95:0] w = '0;
    for (int j = 0; j < 6; j++) begin
      w[j*8 +: 8]     = img[(2*rp)*W + 6*g + j];
      w[(6+j)*8 +: 8] = img[(2*rp+1)*W + 6*g + j];
    end
    return w;
  endfunction

  task automatic do_reset(input logic s);
    @(posedge clk); #1;
    rst = 1'b1; pv = 1'b0; wr = 1'b0; sel = s;
    repeat (2) @(posedge clk); #1;
    got.delete(); fd_cnt = 0; acc_cnt = 0; wv_cycles = 0;
    rst = 1'b0;
  endtask

  // Presents img[lo..hi-1] in order, holding each pixel until accepted.
  task automatic drive(input int lo, input int hi, input int gap, input bit rand_wr);
    int i = lo;
    int n = 0;
    while (i < hi && n < 5000) begin
      pix = img[i];
      pv  = (int'($urandom_range(99)) >= gap);
      if (rand_wr) wr = 1'($urandom_range(1));
      @(negedge clk);
      if (o_pr && pv) i++;
      @(posedge clk); #1;
      n++;
    end
    pv = 1'b0;
  endtask

  task automatic wait_windows(input int n);
    int t = 0;
    while (got.size() < n && t < 400) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bs.pix_ready !== 1'b0) begin errors++; $display("FAIL reset_pix_ready_s: got %b exp 0", bs.pix_ready); end
    checks++; if (bs.win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid_s: got %b exp 0", bs.win_valid); end
    checks++; if (bs.win_data !== 96'h0) begin errors++; $display("FAIL reset_win_data_s: got %h exp 0", bs.win_data); end
    checks++; if (bs.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done_s: got %b exp 0", bs.frame_done); end
    checks++; if (bf.pix_ready !== 1'b0 || bf.win_valid !== 1'b0 || bf.win_data !== 96'h0)
      begin errors++; $display("FAIL reset_f: got pr=%b wv=%b wd=%h exp all 0", bf.pix_ready, bf.win_valid, bf.win_data); end
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bs.pix_ready !== 1'b1) begin errors++; $display("FAIL post_reset_pix_ready: got %b exp 1", bs.pix_ready); end
    checks++; if (bs.win_valid !== 1'b0) begin errors++; $display("FAIL post_reset_win_valid: got %b exp 0", bs.win_valid); end
  endtask

  task automatic test_stream();
    do_reset(1'b0);
    img.delete(); for (int i = 0; i < 48; i++) img.push_back(8'(i));
    wr = 1'b1;
    drive(0, 48, 0, 1'b0);
    wait_windows(4);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL stream_count: got %0d exp 4", got.size()); end
    if (got.size() == 4) begin
      checks++; if (got[0] !== 96'h1d1c1b1a1918_050403020100) begin errors++; $display("FAIL stream_first: got %h exp 1d1c1b1a1918050403020100", got[0]); end
      checks++; if (got[3] !== 96'h2f2e2d2c2b2a_171615141312) begin errors++; $display("FAIL stream_fourth: got %h exp 2f2e2d2c2b2a171615141312", got[3]); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (got[k] !== exp_win(k)) begin errors++; $display("FAIL stream_win%0d: got %h exp %h", k, got[k], exp_win(k)); end
      end
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL stream_frame_done_cnt: got %0d exp 1", fd_cnt); end
    checks++; if (fd_cyc != last_win_cyc + 1) begin errors++; $display("FAIL stream_frame_done_time: got %0d exp %0d", fd_cyc, last_win_cyc + 1); end
    checks++; if (wv_cycles != 4) begin errors++; $display("FAIL stream_emit_dwell: got %0d exp 4", wv_cycles); end
    checks++; if (acc_cnt != 48) begin errors++; $display("FAIL stream_accepts: got %0d exp 48", acc_cnt); end
  endtask

  task automatic test_stall();
    do_reset(1'b0);
    img.delete(); for (int i = 0; i < 48; i++) img.push_back(8'h03);
    wr = 1'b0;
    drive(0, 30, 0, 1'b0);
    pix = 8'h03; pv = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      checks++; if (o_wv !== 1'b1 || o_pr !== 1'b0 || o_wd !== W3)
        begin errors++; $display("FAIL stall_hold%0d: got wv=%b pr=%b wd=%h exp wv=1 pr=0 wd=%h", t, o_wv, o_pr, o_wd, W3); end
    end
    @(posedge clk); #1; wr = 1'b1;
    @(posedge clk); #1; wr = 1'b0; pv = 1'b0;
    @(negedge clk);
    checks++; if (o_pr !== 1'b1 || o_wv !== 1'b0) begin errors++; $display("FAIL stall_release: got pr=%b wv=%b exp pr=1 wv=0", o_pr, o_wv); end
    checks++; if (acc_cnt != 30) begin errors++; $display("FAIL stall_accepts: got %0d exp 30", acc_cnt); end
    wr = 1'b1;
    drive(30, 48, 0, 1'b0);
    wait_windows(4);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL stall_count: got %0d exp 4", got.size()); end
    foreach (got[k]) begin
      checks++; if (got[k] !== W3) begin errors++; $display("FAIL stall_win%0d: got %h exp %h", k, got[k], W3); end
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL stall_frame_done: got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_gaps();
    do_reset(1'b0);
    img.delete(); for (int i = 0; i < 48; i++) img.push_back(8'(i));
    wr = 1'b1;
    drive(0, 48, 50, 1'b0);
    wait_windows(4);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL gaps_count: got %0d exp 4", got.size()); end
    if (got.size() == 4)
      for (int k = 0; k < 4; k++) begin
        checks++; if (got[k] !== exp_win(k)) begin errors++; $display("FAIL gaps_win%0d: got %h exp %h", k, got[k], exp_win(k)); end
      end
    checks++; if (acc_cnt != 48) begin errors++; $display("FAIL gaps_accepts: got %0d exp 48", acc_cnt); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL gaps_frame_done: got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    img.delete(); for (int i = 0; i < 48; i++) img.push_back(8'($urandom));
    drive(0, 48, 40, 1'b1);
    wr = 1'b1;
    wait_windows(4);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL random_count: got %0d exp 4", got.size()); end
    if (got.size() == 4)
      for (int k = 0; k < 4; k++) begin
        checks++; if (got[k] !== exp_win(k)) begin errors++; $display("FAIL random_win%0d: got %h exp %h", k, got[k], exp_win(k)); end
      end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL random_frame_done: got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    img.delete(); for (int i = 0; i < 30; i++) img.push_back(8'($urandom));
    wr = 1'b0;
    drive(0, 30, 0, 1'b0);
    @(negedge clk);
    checks++; if (o_wv !== 1'b1) begin errors++; $display("FAIL rstmid_pre_emit: got wv=%b exp 1", o_wv); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checks++; if (o_wv !== 1'b0 || o_pr !== 1'b0 || o_wd !== 96'h0)
      begin errors++; $display("FAIL rstmid_async: got wv=%b pr=%b wd=%h exp all 0", o_wv, o_pr, o_wd); end
    repeat (2) @(posedge clk); #1;
    got.delete(); fd_cnt = 0; acc_cnt = 0; wv_cycles = 0;
    rst = 1'b0; wr = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (got.size() != 0 || fd_cnt != 0) begin errors++; $display("FAIL rstmid_quiet: got win=%0d fd=%0d exp 0 0", got.size(), fd_cnt); end
    img.delete(); for (int i = 0; i < 48; i++) img.push_back(8'h07);
    drive(0, 48, 0, 1'b0);
    wait_windows(4);
    checks++; if (got.size() != 4) begin errors++; $display("FAIL rstmid_count: got %0d exp 4", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== W7) begin errors++; $display("FAIL rstmid_first: got %h exp %h", got[0], W7); end
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL rstmid_frame_done: got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_full_frame();
    do_reset(1'b1);
    img.delete(); for (int i = 0; i < 24 * 24; i++) img.push_back(8'(i % 256));
    wr = 1'b1;
    drive(0, 24 * 24, 0, 1'b0);
    wait_windows(48);
    checks++; if (got.size() != 48) begin errors++; $display("FAIL full_count: got %0d exp 48", got.size()); end
    if (got.size() == 48)
      for (int k = 0; k < 48; k++) begin
        checks++; if (got[k] !== exp_win(k)) begin errors++; $display("FAIL full_win%0d: got %h exp %h", k, got[k], exp_win(k)); end
      end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL full_frame_done_cnt: got %0d exp 1", fd_cnt); end
    checks++; if (fd_cyc != last_win_cyc + 1) begin errors++; $display("FAIL full_frame_done_time: got %0d exp %0d", fd_cyc, last_win_cyc + 1); end
    checks++; if (wv_cycles != 48) begin errors++; $display("FAIL full_emit_dwell: got %0d exp 48", wv_cycles); end
    // 12 rowpairs x (24 top + 4 x (6 bottom + 1 emit)) cycles, no bubbles
    checks++; if (last_win_cyc - a0 != 623) begin errors++; $display("FAIL full_throughput: got %0d exp 623", last_win_cyc - a0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gaps();
    test_random();
    test_reset_mid();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
